// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage data-memory responder for the RV32I core.
// Steers store bytes onto the 32-bit bus, checks size/alignment, runs a
// req/ack bus transaction while stalling the pipeline, and sign/zero
// extends load data.
// Optional feature: define DMEM_TIMEOUT_EN to abort a transaction that
// has not been acknowledged after TIMEOUT cycles in REQ.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  RW_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [2:0]  func_q, func_d;   // load type kept for extraction
    logic [1:0]  off_q, off_d;     // byte offset kept for lane select

    logic        access, illegal, misaligned, legal;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] load_ext;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        timeout_hit;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TMO = 8'(TIMEOUT);
    logic [7:0] cnt_q, cnt_d;
    // Abort once this REQ cycle would be the TIMEOUT-th without ack.
    assign timeout_hit = ((cnt_q + 8'd1) == TMO);
`else
    assign timeout_hit = 1'b0;
`endif

    assign access = MemRead | MemWrite;

    // Decode legality; a store wins when both requests are raised.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (MemWrite) illegal = RW_type[2] | (RW_type == 3'b011);
        else          illegal = (RW_type == 3'b011) | (RW_type[2:1] == 2'b11);
        misaligned = ((RW_type[1:0] == 2'b01) & addr[0]) |
                     ((RW_type[1:0] == 2'b10) & (|addr[1:0]));
        legal = ~illegal & ~misaligned;
    end

    // Byte enables and lane-replicated store data by access size.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        case (RW_type[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = wdata;
            end
        endcase
    end

    // Lane select and extension of the returned read word.
    always_comb begin
        lane_b   = bus_rdata[{off_q, 3'b000} +: 8];
        lane_h   = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_ext = bus_rdata;
        case (func_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'd0, lane_b};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = bus_rdata;
        endcase
    end

    // Next-state and register-update logic for the IDLE/REQ/DONE FSM.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        func_d      = func_q;
        off_d       = off_q;
`ifdef DMEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (legal) begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = MemWrite;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = be_c;
                        bus_wdata_d = wdata_c;
                        func_d      = RW_type;
                        off_d       = addr[1:0];
`ifdef DMEM_TIMEOUT_EN
                        cnt_d       = 8'd0;
`endif
                        state_d     = REQ;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) rdata_d = load_ext;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    rdata_d   = 32'd0;
                    state_d   = DONE;
                end else begin
`ifdef DMEM_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, all cleared by async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            func_q      <= 3'd0;
            off_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            func_q      <= func_d;
            off_q       <= off_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    // REQ wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign stall     = ((state_q == IDLE) & access & legal) | (state_q == REQ);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule
